// File: rtl/vram_px_scanout_pkg.sv
// Shared constants and types for the framebuffer scan-out path:
// 640x480@60 VGA timing, the 320x240 framebuffer geometry and the
// R3G3B2 pixel layout.
package vram_px_scanout_pkg;

  // Default VGA 640x480@60 timing, in pixel clocks / lines.
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  // Framebuffer geometry: each stored pixel covers a 2x2 block on screen.
  localparam int VGA_FB_WIDTH  = 320;
  localparam int VGA_FB_PIXELS = 76800;

  // Address and counter widths.
  localparam int ADDR_W = $clog2(VGA_FB_PIXELS);  // 17 bits
  localparam int CNT_W  = 10;                     // covers 0..799 and 0..524

  // R3G3B2 field positions inside a framebuffer byte.
  localparam int R_MSB = 7;
  localparam int R_LSB = 5;
  localparam int G_MSB = 4;
  localparam int G_LSB = 2;
  localparam int B_MSB = 1;
  localparam int B_LSB = 0;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  // Timing flags computed from the counters. All are active-high so that
  // an all-zero word means "blank, no sync, not frame start".
  typedef struct packed {
    logic active;
    logic hsync;
    logic vsync;
    logic first;
  } fetch_flags_t;

  localparam fetch_flags_t FLAGS_IDLE = '{default: 1'b0};

  // Split a framebuffer byte into its colour fields.
  function automatic rgb332_t unpack_rgb(input logic [7:0] px);
    rgb332_t c;
    c.r = px[R_MSB:R_LSB];
    c.g = px[G_MSB:G_LSB];
    c.b = px[B_MSB:B_LSB];
    return c;
  endfunction

endpackage

// File: rtl/vram_px_delay_line.sv
// Parameterised shift register used to align the fetch-timing flags with
// the pixel data returning from the SRAM path. Every stage clears to
// RST_VAL so nothing spurious leaves the line right after reset.
module vram_px_delay_line #(
  parameter int                WIDTH   = 1,
  parameter int                DEPTH   = 1,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clkPixel,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  // Shift one stage per pixel clock; reset loads the idle value everywhere.
  always_ff @(posedge clkPixel) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= RST_VAL;
      end
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vram_px_scanout.sv
// Pixel-clock-domain framebuffer reader. Runs the VGA raster counters,
// issues one framebuffer address per pixel clock (each stored pixel is
// shown twice horizontally and on two consecutive lines), and lines the
// returned pixel byte up with delayed sync/blank before driving the DAC.
//
// Timing: counter state in cycle t -> gpu_addr/fetch_* in cycle t+1 ->
// gpu_data sampled on the edge FETCH_LATENCY clocks after gpu_addr
// changed -> vga_* and frame_start in cycle t+FETCH_LATENCY+1.
module vram_px_scanout
  import vram_px_scanout_pkg::*;
#(
  parameter int FETCH_LATENCY = 2,
  parameter int H_ACTIVE      = VGA_H_ACTIVE,
  parameter int H_FP          = VGA_H_FP,
  parameter int H_SYNC        = VGA_H_SYNC,
  parameter int H_BP          = VGA_H_BP,
  parameter int V_ACTIVE      = VGA_V_ACTIVE,
  parameter int V_FP          = VGA_V_FP,
  parameter int V_SYNC        = VGA_V_SYNC,
  parameter int V_BP          = VGA_V_BP,
  parameter int FB_WIDTH      = VGA_FB_WIDTH
) (
  input  logic              clkPixel,
  input  logic              reset,
  output logic [ADDR_W-1:0] gpu_addr,
  input  logic [7:0]        gpu_data,
  output logic              fetch_blank,
  output logic              fetch_vsync,
  output logic [2:0]        vga_r,
  output logic [2:0]        vga_g,
  output logic [1:0]        vga_b,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              vga_blank,
  output logic              frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_STOP    = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_STOP    = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [ADDR_W-1:0] FB_STEP   = ADDR_W'(FB_WIDTH);

  logic [CNT_W-1:0]  h_cnt;
  logic [CNT_W-1:0]  v_cnt;
  logic [ADDR_W-1:0] line_base;
  logic              h_wrap;
  logic              v_wrap;
  fetch_flags_t      flags_now;
  fetch_flags_t      flags_dly;
  logic [ADDR_W-1:0] addr_now;
  rgb332_t           px;

  // Decode raster position into timing flags and the framebuffer address.
  always_comb begin
    h_wrap          = (h_cnt == H_LAST);
    v_wrap          = (v_cnt == V_LAST);
    flags_now       = FLAGS_IDLE;
    flags_now.active = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
    flags_now.hsync  = (h_cnt >= HS_START) && (h_cnt < HS_STOP);
    flags_now.vsync  = (v_cnt >= VS_START) && (v_cnt < VS_STOP);
    flags_now.first  = (h_cnt == '0) && (v_cnt == '0);
    // h_cnt/2 selects the stored pixel; line_base already accounts for the
    // line pair, so no multiplier is needed.
    addr_now = '0;
    if (flags_now.active) begin
      addr_now = line_base + ADDR_W'(h_cnt[CNT_W-1:1]);
    end
  end

  // Raster counters plus the running start address of the current line pair.
  always_ff @(posedge clkPixel) begin
    if (reset) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      line_base <= '0;
    end else if (h_wrap) begin
      h_cnt <= '0;
      if (v_wrap) begin
        // Frame wrap wins: restart at the top with no line add.
        v_cnt     <= '0;
        line_base <= '0;
      end else begin
        v_cnt <= v_cnt + CNT_W'(1);
        // Advance to the next framebuffer line after the second (odd)
        // screen line of each pair.
        if (v_cnt[0] && (v_cnt < V_ACT_END)) begin
          line_base <= line_base + FB_STEP;
        end
      end
    end else begin
      h_cnt <= h_cnt + CNT_W'(1);
    end
  end

  // Fetch-side registers toward the arbiter (undelayed timing).
  always_ff @(posedge clkPixel) begin
    if (reset) begin
      gpu_addr    <= '0;
      fetch_blank <= 1'b1;
      fetch_vsync <= 1'b0;
    end else begin
      gpu_addr    <= addr_now;
      fetch_blank <= !flags_now.active;
      fetch_vsync <= flags_now.vsync;
    end
  end

  vram_px_delay_line #(
    .WIDTH   ($bits(fetch_flags_t)),
    .DEPTH   (FETCH_LATENCY),
    .RST_VAL (FLAGS_IDLE)
  ) u_align (
    .clkPixel (clkPixel),
    .reset    (reset),
    .din      (flags_now),
    .dout     (flags_dly)
  );

  assign px = unpack_rgb(gpu_data);

  // Output register: colour, syncs and frame_start all change on one edge.
  always_ff @(posedge clkPixel) begin
    if (reset) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank   <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      vga_hs      <= !flags_dly.hsync;
      vga_vs      <= !flags_dly.vsync;
      vga_blank   <= !flags_dly.active;
      frame_start <= flags_dly.first;
      // Data returned outside the visible window is never shown.
      if (flags_dly.active) begin
        vga_r <= px.r;
        vga_g <= px.g;
        vga_b <= px.b;
      end else begin
        vga_r <= '0;
        vga_g <= '0;
        vga_b <= '0;
      end
    end
  end

endmodule

// File: doc/vram_px_scanout.md
Name: vram_px_scanout

Overview:
- Pixel-clock-domain reader for the 320x240 R3G3B2 pixel framebuffer held in external SRAM.
- Generates 640x480@60 VGA timing and drives the 17-bit pixel address toward the SRAM arbiter path, doubling pixels horizontally and vertically.
- Consumes the returned 8-bit pixel data, aligns it with delayed sync/blank, and drives the VGA colour outputs.
- It is the GPU-side reader opposite the CPU write path into the same framebuffer.

Parameters:
- FETCH_LATENCY, 2, pixel clocks from gpu_addr change to matching gpu_data being valid (legal range 1..7).
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch.
- H_SYNC, 96, hsync width.
- H_BP, 48, horizontal back porch.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch.
- V_SYNC, 2, vsync width.
- V_BP, 33, vertical back porch.
- FB_WIDTH, 320, framebuffer pixels per line.

Ports:
- clkPixel  in  1  25MHz pixel clock.
- reset  in  1  synchronous, active-high reset.
- gpu_addr  out  17  pixel address to arbiter, 0..76799.
- gpu_data  in  8  pixel data returned FETCH_LATENCY cycles after address.
- fetch_blank  out  1  undelayed blank in fetch timing, drives arbiter blank input.
- fetch_vsync  out  1  undelayed active-high vsync in fetch timing, drives arbiter vsync input.
- vga_r  out  3  red, gpu_data[7:5].
- vga_g  out  3  green, gpu_data[4:2].
- vga_b  out  2  blue, gpu_data[1:0].
- vga_hs  out  1  hsync, active low.
- vga_vs  out  1  vsync, active low.
- vga_blank  out  1  display blank, aligned with colour.
- frame_start  out  1  one-cycle pulse, aligned with the first visible pixel of each frame.

Behaviour:
- Counters h_cnt 0..799 and v_cnt 0..524.
  - h_cnt increments every clock and wraps 799->0.
  - On that wrap v_cnt increments and wraps 524->0.
- Active region: h_cnt<640 and v_cnt<480.
  - fetch_blank = !active, registered.
  - fetch_vsync high for v_cnt in 490..491.
  - hsync region is h_cnt 656..751.
- Address generation (no multiplier):
  - line_base adds 320 after every odd active line (v_cnt[0]==1 at h wrap).
  - line_base clears at v wrap.
  - gpu_addr = line_base + h_cnt[9:1] during active; 0 outside active.
  - gpu_addr is registered; the maximum value is 76799 at (639,479).
- Alignment:
  - Each fetch-timing signal (active, hsync, vsync, frame-first-pixel) passes through a shift register of length FETCH_LATENCY, plus 1 output register.
  - Colour is registered from gpu_data when the delayed active is set, and forced to 0 when it is clear.
  - All vga_* outputs and frame_start change on the same edge; total pipeline is FETCH_LATENCY+1 cycles from the counter state.
- Reset values:
  - h_cnt=0, v_cnt=0, line_base=0, gpu_addr=0.
  - fetch_blank=1, fetch_vsync=0.
  - vga_r/g/b=0, vga_hs=1, vga_vs=1, vga_blank=1, frame_start=0.
  - All delay-line stages clear to the inactive/blank value, so no spurious sync or colour appears during the first FETCH_LATENCY cycles after reset.
- Reset mid-frame: takes effect next edge; timing restarts at (0,0); first frame_start occurs FETCH_LATENCY+1 cycles after reset deasserts.
- gpu_data content outside the delayed active window is ignored.
- Simultaneous h wrap and v wrap at (799,524):
  - v_cnt->0 and line_base->0 in the same cycle.
  - No +320 add occurs on that edge.

Decomposition:
- Shared package: VGA 640x480 timing constants, FB_WIDTH=320, FB_PIXELS=76800, R3G3B2 field slice positions.
- One natural sub-module: vram_px_delay_line, a parameterised shift register (width, depth, reset value) used for the sync/blank/frame_start alignment.

Test Plan:
- Release reset, run 420000 cycles (one frame = 800*525 = 420000): vga_hs low exactly 96 cycles per 800; vga_vs low exactly 2 lines (1600 cycles) per frame; frame_start pulses once per 420000 cycles.
- Address trace: at (h,v)=(0,0)->0, (1,0)->0, (2,0)->1, (0,1)->0, (0,2)->320, (639,479)->76799; gpu_addr=0 whenever blank.
- Model memory mem[a]=a[7:0] with FETCH_LATENCY=2 delay: the first visible pixels show 0x00,0x00,0x01,0x01; colour fields split correctly, e.g. 0xE3 -> r=7, g=0, b=3.
- During blank with gpu_data forced to 0xFF: vga_r/g/b stay 0 and vga_blank=1.
- Rebuild with FETCH_LATENCY=4: the alignment checks above still pass, and the outputs shift by exactly 2 additional cycles relative to fetch_blank.
- Assert reset at (h,v)=(300,200) for 3 cycles: outputs hold reset values; after release the counters restart at (0,0) and frame_start fires after FETCH_LATENCY+1 cycles.
